ps2_mouse_receiver: RTL and testbench
=====================================

Name: ps2_mouse_receiver

Overview:
- PS/2 device-to-host byte receiver for the mouse path; sits directly upstream of the mouse transceiver state machine that builds status/X/Y/Z packets for the bus-mapped mouse peripheral.
- Synchronises the open-collector CLK_MOUSE/DATA_MOUSE lines and deserialises 11-bit frames: start, 8 data LSB-first, odd parity, stop.
- Delivers each byte with a one-cycle ready strobe and an error code; aborts stalled frames on timeout.

Parameters:
- TIMEOUT_CYCLES, 50000, max CLK cycles between PS/2 falling edges inside a frame (0.5 ms at 100 MHz).
- SYNC_STAGES, 2, flip-flop stages on each PS/2 input (min 2).
- FILTER_CYCLES, 8, consecutive low samples required for a clock edge when the glitch filter is compiled in.

Ports:
- CLK  input  1  system clock, 100 MHz.
- RESET  input  1  synchronous, active-high reset.
- READ_ENABLE  input  1  high = new frames may start; driven low by the transceiver while it transmits to the mouse.
- CLK_MOUSE_IN  input  1  raw PS/2 clock line (input side of the tristate pad).
- DATA_MOUSE_IN  input  1  raw PS/2 data line.
- BYTE_READ  output  8  last received data byte.
- BYTE_ERROR_CODE  output  2  bit0 parity error, bit1 stop-bit error, for the byte on BYTE_READ.
- BYTE_READY  output  1  one-cycle strobe: BYTE_READ/BYTE_ERROR_CODE updated this cycle.

Behaviour:
- Reset: BYTE_READ=8'h00, BYTE_ERROR_CODE=2'b00, BYTE_READY=0, state IDLE, bit counter 0, timeout counter 0, sync flops preset to 1 (idle-high bus).
- Reset is synchronous; asserting mid-frame discards the partial byte; no strobe.
- Edge: falling edge = previous synced clock 1, current 0. All PS/2 data sampled from the synced data line in the cycle the edge is detected.
- Latency: BYTE_READY asserts the cycle after the stop-bit edge is detected.
- States:
  - IDLE: on edge with READ_ENABLE=1 and data=0 -> DATA, bit counter 0. Edge with data=1 (glitch) or READ_ENABLE=0 -> stay IDLE.
  - DATA: each edge shifts data into bit[counter] (LSB first); after bit 7 -> PARITY.
  - PARITY: edge captures parity bit -> STOP.
  - STOP: edge captures stop bit -> DONE.
  - DONE: one cycle; loads BYTE_READ, sets code: bit0 = (XOR of 8 data bits and parity) == 0, bit1 = (stop == 0); BYTE_READY=1 -> IDLE.
- Bytes with errors are still delivered, flagged; the consumer decides.
- Timeout: counter clears on each edge and in IDLE, increments otherwise. If it reaches TIMEOUT_CYCLES outside IDLE -> IDLE, partial byte discarded, no strobe.
- READ_ENABLE falling mid-frame: the current frame completes normally; only frame starts are gated.
- BYTE_READ/BYTE_ERROR_CODE hold their values between strobes.
- BYTE_READY never asserts on consecutive cycles (at most once per frame).

Optional Feature:
- Macro PS2_GLITCH_FILTER_EN.
- Defined: the synced clock must read 0 for FILTER_CYCLES consecutive cycles before an edge is declared (edge fires once per low period; re-armed after clock returns 1). Data is sampled at the filtered edge. Adds FILTER_CYCLES-1 cycles edge latency.
- Undefined: plain one-cycle falling-edge detect as above; FILTER_CYCLES unused.

Decomposition:
- Package ps2_pkg: receiver state enum (IDLE, DATA, PARITY, STOP, DONE), error-bit index constants (ERR_PARITY=0, ERR_STOP=1), DATA_BITS=8.
- Sub-module ps2_sync_edge: SYNC_STAGES synchroniser for both lines plus falling-edge detect / optional filter; outputs synced data and edge strobe. Instantiated once.

Test Plan:
- Frame 0xFA, parity 1, stop 1, 12.5 kHz clock -> one BYTE_READY pulse, BYTE_READ=0xFA, BYTE_ERROR_CODE=00.
- Frame 0x08 with parity 1 (wrong) -> BYTE_READ=0x08, BYTE_ERROR_CODE=01; frame 0x08, parity 0, stop 0 -> code 10.
- Clock stops after 4 data bits for TIMEOUT_CYCLES+10 cycles -> no BYTE_READY; following frame 0x55, parity 1 -> BYTE_READ=0x55, code 00.
- READ_ENABLE=0 throughout frame 0xAA -> no strobe, BYTE_READ keeps 0x00; READ_ENABLE dropped after start bit of 0xAA -> byte still delivered.
- RESET pulsed after bit 5 of 0x3C -> outputs at reset values, no strobe; next frame 0x3C, parity 1 -> received correctly.
- With PS2_GLITCH_FILTER_EN: 3-cycle low glitch on CLK_MOUSE_IN in IDLE and mid-frame -> ignored; frame 0xFA still decoded 0xFA, code 00.

Source files
------------

// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared constants for the PS/2 mouse byte receiver: receiver
//                state encoding, error-code bit positions, frame data width
//                and an odd-parity helper.
//  Revision    : 1.0  initial release
// ============================================================================
package ps2_pkg;

    // Data bits carried by one PS/2 frame
    localparam int DATA_BITS = 8;

    // Bit positions inside BYTE_ERROR_CODE
    localparam int ERR_PARITY = 0;
    localparam int ERR_STOP   = 1;

    // Receiver state encoding
    typedef logic [2:0] rx_state_t;
    localparam rx_state_t IDLE   = 3'd0;
    localparam rx_state_t DATA   = 3'd1;
    localparam rx_state_t PARITY = 3'd2;
    localparam rx_state_t STOP   = 3'd3;
    localparam rx_state_t DONE   = 3'd4;

    // Odd parity holds when data plus parity bit carry an odd number of ones
    function automatic logic odd_parity_ok(input logic [DATA_BITS-1:0] data,
                                           input logic                 par);
        return ^{data, par};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ps2_sync_edge
//  Description : Synchronises the raw PS/2 clock and data lines into the CLK
//                domain and produces a single-cycle falling-edge strobe for
//                the PS/2 clock. Compile-time option PS2_GLITCH_FILTER_EN
//                replaces the plain edge detect with a low-period filter that
//                requires FILTER_CYCLES consecutive low samples.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_sync_edge #(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 8
) (
    input  logic CLK,
    input  logic RESET,
    input  logic CLK_MOUSE_IN,
    input  logic DATA_MOUSE_IN,
    output logic data_sync,
    output logic fall_edge
);

    // Elaboration-time sanity check of the configuration
    if (SYNC_STAGES < 2 || FILTER_CYCLES < 1) begin : g_param_check
        $error("ps2_sync_edge: SYNC_STAGES must be >= 2 and FILTER_CYCLES >= 1");
    end

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   w_clk_sync;

    // Multi-stage synchronisers, preset high to match an idle bus
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0],  CLK_MOUSE_IN};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], DATA_MOUSE_IN};
        end
    end

    assign w_clk_sync = r_clk_sync[SYNC_STAGES-1];
    assign data_sync  = r_data_sync[SYNC_STAGES-1];

`ifdef PS2_GLITCH_FILTER_EN
    localparam int                c_cnt_w  = $clog2(FILTER_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(FILTER_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_hit = c_cnt_w'(FILTER_CYCLES - 1);

    logic [c_cnt_w-1:0] r_low_cnt;

    // Count consecutive low samples; saturate so the edge fires once per low period
    always_ff @(posedge CLK) begin
        if (RESET || w_clk_sync) begin
            r_low_cnt <= '0;
        end else if (r_low_cnt != c_cnt_max) begin
            r_low_cnt <= r_low_cnt + c_cnt_w'(1);
        end
    end

    // Edge on the FILTER_CYCLES-th consecutive low sample
    assign fall_edge = ~w_clk_sync && (r_low_cnt == c_cnt_hit);
`else
    logic r_clk_prev;

    // Remember the previous synchronised clock level for edge detection
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_prev <= w_clk_sync;
        end
    end

    assign fall_edge = r_clk_prev & ~w_clk_sync;
`endif

endmodule
`default_nettype wire

// File: rtl/ps2_mouse_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ps2_mouse_receiver
//  Description : PS/2 device-to-host byte receiver. Deserialises 11-bit
//                frames (start, 8 data LSB first, odd parity, stop), reports
//                parity/stop errors and strobes BYTE_READY for one cycle per
//                received byte. Stalled frames are dropped after
//                TIMEOUT_CYCLES without a PS/2 clock edge.
//                Optional macro PS2_GLITCH_FILTER_EN enables the PS/2 clock
//                low-period filter in the edge detector.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_mouse_receiver
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_CYCLES  = 8
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 READ_ENABLE,
    input  logic                 CLK_MOUSE_IN,
    input  logic                 DATA_MOUSE_IN,
    output logic [DATA_BITS-1:0] BYTE_READ,
    output logic [1:0]           BYTE_ERROR_CODE,
    output logic                 BYTE_READY
);

    localparam int                c_to_w   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_to_w-1:0] c_to_max = c_to_w'(TIMEOUT_CYCLES);
    localparam logic [2:0]        c_last_bit = 3'(DATA_BITS - 1);

    logic                 w_data;
    logic                 w_fall;
    logic                 w_timeout;

    rx_state_t            r_state;
    logic [2:0]           r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_parity;
    logic [c_to_w-1:0]    r_to_cnt;

    ps2_sync_edge #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_CYCLES (FILTER_CYCLES)
    ) u_sync_edge (
        .CLK           (CLK),
        .RESET         (RESET),
        .CLK_MOUSE_IN  (CLK_MOUSE_IN),
        .DATA_MOUSE_IN (DATA_MOUSE_IN),
        .data_sync     (w_data),
        .fall_edge     (w_fall)
    );

    // A frame in progress is abandoned when the gap since the last edge hits the limit;
    // DONE is a single-cycle state and never times out
    assign w_timeout = (r_state != IDLE) && (r_state != DONE) && (r_to_cnt == c_to_max);

    // Inter-edge gap counter: cleared while idle and on every PS/2 clock edge
    always_ff @(posedge CLK) begin
        if (RESET || r_state == IDLE || w_fall || w_timeout) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + c_to_w'(1);
        end
    end

    // Frame state machine; the result registers are loaded on the stop-bit edge so
    // that BYTE_READY is high during the DONE cycle, one cycle after that edge
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state         <= IDLE;
            r_bit_cnt       <= '0;
            r_shift         <= '0;
            r_parity        <= 1'b0;
            BYTE_READ       <= '0;
            BYTE_ERROR_CODE <= 2'b00;
            BYTE_READY      <= 1'b0;
        end else begin
            BYTE_READY <= 1'b0;
            if (w_timeout) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_fall && READ_ENABLE && !w_data) begin
                            r_state   <= DATA;
                            r_bit_cnt <= '0;
                        end
                    end
                    DATA: begin
                        if (w_fall) begin
                            r_shift[r_bit_cnt] <= w_data;
                            if (r_bit_cnt == c_last_bit) begin
                                r_state <= PARITY;
                            end else begin
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                    PARITY: begin
                        if (w_fall) begin
                            r_parity <= w_data;
                            r_state  <= STOP;
                        end
                    end
                    STOP: begin
                        if (w_fall) begin
                            BYTE_READ                   <= r_shift;
                            BYTE_ERROR_CODE[ERR_PARITY] <= ~odd_parity_ok(r_shift, r_parity);
                            BYTE_ERROR_CODE[ERR_STOP]   <= ~w_data;
                            BYTE_READY                  <= 1'b1;
                            r_state                     <= DONE;
                        end
                    end
                    DONE: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ps2_mouse_receiver.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_mouse_receiver
//  Description : Self-checking bench for ps2_mouse_receiver. A PS/2 device
//                model drives frames; expected bytes go into a scoreboard
//                queue and a monitor compares every BYTE_READY strobe.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_mouse_receiver;

    localparam int TO   = 400;
    localparam int SYNC = 2;
    localparam int FILT = 8;
`ifdef PS2_GLITCH_FILTER_EN
    localparam int LAT = SYNC + 1 + FILT - 1;
`else
    localparam int LAT = SYNC + 1;
`endif

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       READ_ENABLE = 1'b0;
    logic       CLK_MOUSE_IN = 1'b1;
    logic       DATA_MOUSE_IN = 1'b1;
    logic [7:0] BYTE_READ;
    logic [1:0] BYTE_ERROR_CODE;
    logic       BYTE_READY;

    ps2_mouse_receiver #(
        .TIMEOUT_CYCLES (TO),
        .SYNC_STAGES    (SYNC),
        .FILTER_CYCLES  (FILT)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .READ_ENABLE     (READ_ENABLE),
        .CLK_MOUSE_IN    (CLK_MOUSE_IN),
        .DATA_MOUSE_IN   (DATA_MOUSE_IN),
        .BYTE_READ       (BYTE_READ),
        .BYTE_ERROR_CODE (BYTE_ERROR_CODE),
        .BYTE_READY      (BYTE_READY)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        logic [1:0] code;
        int         fall;
    } exp_t;

    exp_t       sbq[$];
    int         errors = 0;
    int         checks = 0;
    logic [7:0] m_last_b = 8'h00;
    logic [1:0] m_last_c = 2'b00;
    logic       prev_rdy = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected byte
    always @(negedge CLK) begin : mon
        exp_t e;
        if (BYTE_READY === 1'b1) begin
            check("ready_not_consecutive", {31'd0, prev_rdy}, 32'd0);
            if (sbq.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("byte_read", {24'd0, BYTE_READ}, {24'd0, e.b});
                check("error_code", {30'd0, BYTE_ERROR_CODE}, {30'd0, e.code});
                check("ready_latency", cyc - e.fall, LAT);
            end
        end
        prev_rdy <= BYTE_READY;
    end

    // PS/2 device model: drives nedges bits of the frame; glitch_bit inserts a short
    // low pulse on the clock during the high phase after that bit
    task automatic send_frame(input logic [7:0] b, input bit par_err, input bit stop_err,
                              input int nedges, input bit drop_re, input int glitch_bit,
                              input int hp);
        logic [10:0] fr;
        logic        p;
        logic        en;
        exp_t        e;
        p  = (($countones(b) % 2) == 0) ^ par_err;
        fr = {~stop_err, p, b, 1'b0};
        @(negedge CLK);
        en = READ_ENABLE;
        for (int i = 0; i < nedges; i++) begin
            DATA_MOUSE_IN = fr[i];
            repeat (hp) @(negedge CLK);
            CLK_MOUSE_IN = 1'b0;
            if (i == 10 && en) begin
                e.b     = b;
                e.code  = {fr[10] == 1'b0, (($countones(b) + int'(p)) % 2) == 0};
                e.fall  = cyc;
                sbq.push_back(e);
                m_last_b = e.b;
                m_last_c = e.code;
            end
            repeat (hp) @(negedge CLK);
            CLK_MOUSE_IN = 1'b1;
            if (i == 0 && drop_re) READ_ENABLE = 1'b0;
            if (i == glitch_bit) begin
                repeat (hp / 2) @(negedge CLK);
                CLK_MOUSE_IN = 1'b0;
                repeat (3) @(negedge CLK);
                CLK_MOUSE_IN = 1'b1;
            end
        end
        repeat (hp) @(negedge CLK);
        DATA_MOUSE_IN = 1'b1;
        repeat (hp) @(negedge CLK);
    endtask

    // After a frame: nothing left undelivered, outputs hold the last delivered byte
    task automatic frame_done();
        repeat (20) @(negedge CLK);
        check("missing_strobe", sbq.size(), 0);
        sbq.delete();
        check("hold_byte", {24'd0, BYTE_READ}, {24'd0, m_last_b});
        check("hold_code", {30'd0, BYTE_ERROR_CODE}, {30'd0, m_last_c});
    endtask

    initial begin : main
        logic [7:0] rb;
        bit         pe;
        bit         se;
        repeat (5) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        check("reset_byte", {24'd0, BYTE_READ}, 32'd0);
        check("reset_code", {30'd0, BYTE_ERROR_CODE}, 32'd0);
        check("reset_ready", {31'd0, BYTE_READY}, 32'd0);

        // Frame start gated by READ_ENABLE
        send_frame(8'hAA, 0, 0, 11, 0, -1, 20);
        frame_done();
        READ_ENABLE = 1'b1;

        // Short clock glitch while idle with data high
        repeat (5) @(negedge CLK);
        CLK_MOUSE_IN = 1'b0;
        repeat (3) @(negedge CLK);
        CLK_MOUSE_IN = 1'b1;
        repeat (10) @(negedge CLK);

        send_frame(8'hFA, 0, 0, 11, 0, -1, 25);
        frame_done();
        send_frame(8'h08, 1, 0, 11, 0, -1, 18);
        frame_done();
        send_frame(8'h08, 1, 1, 11, 0, -1, 22);
        frame_done();

        // Stalled frame is dropped, the next one decodes cleanly
        send_frame(8'h55, 0, 0, 5, 0, -1, 20);
        repeat (TO + 10) @(negedge CLK);
        send_frame(8'h55, 0, 0, 11, 0, -1, 20);
        frame_done();

        // READ_ENABLE falling after the start bit does not abort the frame
        send_frame(8'hAA, 0, 0, 11, 1, -1, 20);
        frame_done();
        READ_ENABLE = 1'b1;

        // Reset mid-frame discards the partial byte
        send_frame(8'h3C, 0, 0, 7, 0, -1, 20);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        m_last_b = 8'h00;
        m_last_c = 2'b00;
        check("midreset_byte", {24'd0, BYTE_READ}, 32'd0);
        check("midreset_code", {30'd0, BYTE_ERROR_CODE}, 32'd0);
        send_frame(8'h3C, 0, 0, 11, 0, -1, 20);
        frame_done();

`ifdef PS2_GLITCH_FILTER_EN
        // Short clock glitches inside a frame are filtered out
        send_frame(8'hFA, 0, 0, 11, 0, 4, 24);
        frame_done();
`endif

        // Randomised frames with occasional parity/stop errors
        for (int n = 0; n < 20; n++) begin
            rb = 8'($urandom);
            pe = ($urandom_range(0, 3) == 0);
            se = ($urandom_range(0, 3) == 0);
            send_frame(rb, pe, se, 11, 0, -1, $urandom_range(12, 40));
            frame_done();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
